// File: rtl/c_drain.sv
// c_drain: captures saved 16-bit C results into a small FIFO and
// streams them out low byte first over a valid/ready byte port.
module c_drain #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [15:0]                in_data,
  input  logic                       in_save,
  output logic [7:0]                 out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULLV = CW'(DEPTH);

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic          ph;

  logic          xfer;
  logic          pop;
  logic          full;
  logic          push;
  logic          drop;
  logic [15:0]   head;

  assign out_valid = (count != '0);
  assign full      = (count == FULLV);
  assign xfer      = out_valid && out_ready;
  assign pop       = xfer && ph;
  assign push      = in_save && (!full || pop);
  assign drop      = in_save && full && !pop;
  assign head      = mem[rp];

  // Gate with valid so unwritten memory never leaks X onto the pins
  always_comb begin
    out_data = 8'h00;
    if (out_valid)
      out_data = ph ? head[15:8] : head[7:0];
  end

  always_ff @(posedge clk) begin
    if (!rst && push)
      mem[wp] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp       <= '0;
      rp       <= '0;
      count    <= '0;
      ph       <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (push)
        wp <= wp + 1'b1;
      if (xfer)
        ph <= ~ph;
      if (pop)
        rp <= rp + 1'b1;
      if (drop)
        overflow <= 1'b1;
      unique case (1'b1)
        (push && !pop): count <= count + 1'b1;
        (pop && !push): count <= count - 1'b1;
        default:        count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_c_drain.sv
// tb_c_drain: directed self-checking bench for c_drain.
// Inputs change and outputs are sampled on the falling edge.
module tb_c_drain;

  logic        clk;
  logic        rst;
  logic [15:0] in_data;
  logic        in_save;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  count;
  logic        overflow;

  int pass;
  int total;

  c_drain #(.DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_save   (in_save),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_save = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    in_data = 16'hFFFF;
    do_reset();
    total++;
    if ({out_valid, count, overflow} !== 5'b0_000_0)
      $display("FAIL reset_state valid=%b count=%0d ovf=%b want 0 0 0",
               out_valid, count, overflow);
    else pass++;
  endtask

  task automatic test_single_word();
    in_save = 1'b1;
    in_data = 16'h3C00;
    out_ready = 1'b1;
    tick();
    in_save = 1'b0;
    total++;
    if (out_valid !== 1'b1 || out_data !== 8'h00 || count !== 3'd1)
      $display("FAIL single_lo valid=%b data=%h count=%0d want 1 00 1",
               out_valid, out_data, count);
    else pass++;
    tick();
    total++;
    if (out_valid !== 1'b1 || out_data !== 8'h3C)
      $display("FAIL single_hi valid=%b data=%h want 1 3c",
               out_valid, out_data);
    else pass++;
    tick();
    total++;
    if (out_valid !== 1'b0 || count !== 3'd0)
      $display("FAIL single_empty valid=%b count=%0d want 0 0",
               out_valid, count);
    else pass++;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_save = 1'b1;
    in_data = 16'hBEEF;
    tick();
    in_save = 1'b0;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (out_valid !== 1'b1 || out_data !== 8'hEF || count !== 3'd1)
        $display("FAIL stall_%0d valid=%b data=%h count=%0d want 1 ef 1",
                 i, out_valid, out_data, count);
      else pass++;
      tick();
    end
    out_ready = 1'b1;
    total++;
    if (out_data !== 8'hEF || count !== 3'd1)
      $display("FAIL bp_lo data=%h count=%0d want ef 1", out_data, count);
    else pass++;
    tick();
    total++;
    if (out_data !== 8'hBE || count !== 3'd1)
      $display("FAIL bp_hi data=%h count=%0d want be 1", out_data, count);
    else pass++;
    tick();
    total++;
    if (count !== 3'd0 || out_valid !== 1'b0)
      $display("FAIL bp_empty count=%0d valid=%b want 0 0", count, out_valid);
    else pass++;
  endtask

  task automatic test_fill_overflow();
    logic [7:0] exp [8];
    exp = '{8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'h04, 8'h00};
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      in_save = 1'b1;
      in_data = 16'(i);
      tick();
    end
    in_save = 1'b0;
    total++;
    if (count !== 3'd4 || overflow !== 1'b1)
      $display("FAIL fill_state count=%0d ovf=%b want 4 1", count, overflow);
    else pass++;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (out_valid !== 1'b1 || out_data !== exp[i])
        $display("FAIL fill_byte_%0d valid=%b data=%h want 1 %h",
                 i, out_valid, out_data, exp[i]);
      else pass++;
      tick();
    end
    total++;
    if (out_valid !== 1'b0 || count !== 3'd0)
      $display("FAIL fill_drained valid=%b count=%0d want 0 0",
               out_valid, count);
    else pass++;
  endtask

  task automatic test_full_pop();
    logic [7:0] exp [8];
    exp = '{8'h22, 8'h22, 8'h33, 8'h33, 8'h44, 8'h44, 8'hAA, 8'hAA};
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      in_save = 1'b1;
      in_data = {4'(i), 4'(i), 4'(i), 4'(i)};
      tick();
    end
    in_save = 1'b0;
    out_ready = 1'b1;
    tick();
    total++;
    if (out_data !== 8'h11 || count !== 3'd4)
      $display("FAIL fp_hi0 data=%h count=%0d want 11 4", out_data, count);
    else pass++;
    in_save = 1'b1;
    in_data = 16'hAAAA;
    tick();
    in_save = 1'b0;
    total++;
    if (count !== 3'd4 || overflow !== 1'b0)
      $display("FAIL fp_state count=%0d ovf=%b want 4 0", count, overflow);
    else pass++;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (out_valid !== 1'b1 || out_data !== exp[i])
        $display("FAIL fp_byte_%0d valid=%b data=%h want 1 %h",
                 i, out_valid, out_data, exp[i]);
      else pass++;
      tick();
    end
    total++;
    if (out_valid !== 1'b0)
      $display("FAIL fp_drained valid=%b want 0", out_valid);
    else pass++;
  endtask

  task automatic test_wrap();
    logic [7:0] got [$];
    logic [15:0] w;
    out_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (out_valid && out_ready)
        got.push_back(out_data);
      in_save = (c % 3 == 0) && (c / 3 < 10);
      in_data = 16'h1000 + 16'(c / 3);
      tick();
    end
    in_save = 1'b0;
    total++;
    if (got.size() != 20)
      $display("FAIL wrap_len got=%0d want 20", got.size());
    else pass++;
    for (int i = 0; i < 20 && i < got.size(); i++) begin
      w = 16'h1000 + 16'(i / 2);
      total++;
      if (got[i] !== ((i % 2) ? w[15:8] : w[7:0]))
        $display("FAIL wrap_byte_%0d got=%h want %h", i, got[i],
                 (i % 2) ? w[15:8] : w[7:0]);
      else pass++;
    end
    total++;
    if (overflow !== 1'b0 || count !== 3'd0)
      $display("FAIL wrap_end ovf=%b count=%0d want 0 0", overflow, count);
    else pass++;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    in_save = 1'b1;
    in_data = 16'h1234;
    tick();
    in_save = 1'b0;
    total++;
    if (out_data !== 8'h34)
      $display("FAIL rm_lo data=%h want 34", out_data);
    else pass++;
    tick();
    rst = 1'b1;
    out_ready = 1'b0;
    in_save = 1'b1;
    in_data = 16'hDEAD;
    tick();
    rst = 1'b0;
    in_save = 1'b0;
    total++;
    if (out_valid !== 1'b0 || count !== 3'd0 || overflow !== 1'b0)
      $display("FAIL rm_state valid=%b count=%0d ovf=%b want 0 0 0",
               out_valid, count, overflow);
    else pass++;
    in_save = 1'b1;
    in_data = 16'h5678;
    out_ready = 1'b1;
    tick();
    in_save = 1'b0;
    total++;
    if (out_valid !== 1'b1 || out_data !== 8'h78)
      $display("FAIL rm_new_lo valid=%b data=%h want 1 78",
               out_valid, out_data);
    else pass++;
    tick();
    total++;
    if (out_valid !== 1'b1 || out_data !== 8'h56)
      $display("FAIL rm_new_hi valid=%b data=%h want 1 56",
               out_valid, out_data);
    else pass++;
    tick();
    total++;
    if (out_valid !== 1'b0)
      $display("FAIL rm_empty valid=%b want 0", out_valid);
    else pass++;
  endtask

  initial begin
    pass = 0;
    total = 0;
    rst = 1'b1;
    in_save = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    tick();
    test_reset();
    test_single_word();
    test_backpressure();
    test_fill_overflow();
    test_full_pop();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
